// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes and the
// burst FSM state type.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/usr_step_unit.sv
// Combinational one-step next-value function of the shift register.
// Used for both single-step operation and each step of a burst.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_reg,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sir,
  input  logic             i_sil,
  output logic [WIDTH-1:0] o_next
);

  always_comb begin
    o_next = i_reg;
    case (i_mode)
      MODE_SHR:  o_next = {i_sir, i_reg[WIDTH-1:1]};
      MODE_SHL:  o_next = {i_reg[WIDTH-2:0], i_sil};
      MODE_LOAD: o_next = i_d;
      MODE_ROR:  o_next = {i_reg[0], i_reg[WIDTH-1:1]};
      MODE_ROL:  o_next = {i_reg[WIDTH-2:0], i_reg[WIDTH-1]};
      MODE_ASR:  o_next = {i_reg[WIDTH-1], i_reg[WIDTH-1:1]};
      default:   o_next = i_reg;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with single-step mode and a burst
// engine that repeats one latched operation up to WIDTH times.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic [2:0]       i_s,
  input  logic             i_sir,
  input  logic             i_sil,
  input  logic             i_start,
  input  logic [CW-1:0]    i_cnt,
  input  logic             i_oe,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sor,
  output logic             o_sol,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_reg;
  state_t           r_state;
  logic [CW-1:0]    r_remaining;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_next;
  logic [2:0]       w_mode;
  logic [CW-1:0]    w_clamped;
  logic [CW-1:0]    w_start_cnt;

  // During a burst the latched mode drives the step unit; otherwise S is live.
  assign w_mode = (r_state == ST_RUN) ? r_mode : i_s;

  always_comb begin
    w_clamped   = (i_cnt > CNT_MAX) ? CNT_MAX : i_cnt;
    w_start_cnt = (i_s == MODE_LOAD) ? CW'(1) : w_clamped;
  end

  usr_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_reg (r_reg),
    .i_mode(w_mode),
    .i_d   (i_d),
    .i_sir (i_sir),
    .i_sil (i_sil),
    .o_next(w_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg       <= '0;
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_mode      <= MODE_HOLD;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            // The request edge itself performs no operation.
            r_mode      <= i_s;
            r_remaining <= w_start_cnt;
            if (w_start_cnt == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_reg <= w_next;
          end
        end
        ST_RUN: begin
          r_reg       <= w_next;
          r_remaining <= r_remaining - CW'(1);
          if (r_remaining == CW'(1)) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_q    = i_oe ? r_reg : '0;
  assign o_sor  = r_reg[0];
  assign o_sol  = r_reg[WIDTH-1];
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): directed
// scenarios plus randomized steps and bursts against an arithmetic model.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [W-1:0]  i_d     = '0;
  logic [2:0]    i_s     = '0;
  logic          i_sir   = 1'b0;
  logic          i_sil   = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_cnt   = '0;
  logic          i_oe    = 1'b1;
  logic [W-1:0]  o_q;
  logic          o_sor, o_sol, o_busy, o_done;

  int vectors     = 0;
  int miscompares = 0;

  universal_shift_register #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_d), .i_s(i_s),
    .i_sir(i_sir), .i_sil(i_sil), .i_start(i_start), .i_cnt(i_cnt),
    .i_oe(i_oe), .o_q(o_q), .o_sor(o_sor), .o_sol(o_sol),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: one operation expressed as plain integer arithmetic.
  function automatic logic [7:0] m_step(input logic [7:0] v, input logic [2:0] m,
                                        input logic [7:0] d, input logic sir,
                                        input logic sil);
    int u;
    u = int'(v);
    case (m)
      3'd1: u = (u / 2) + (sir ? 128 : 0);
      3'd2: u = ((u * 2) % 256) + (sil ? 1 : 0);
      3'd3: u = int'(d);
      3'd4: u = (u / 2) + ((u % 2) * 128);
      3'd5: u = ((u * 2) % 256) + (u / 128);
      3'd6: u = (u / 2) + ((u >= 128) ? 128 : 0);
      default: ;
    endcase
    return 8'(u);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    i_start = 1'b0;
    i_s     = 3'b011;
    i_d     = v;
    tick();
    i_s     = 3'b000;
  endtask

  task automatic run_burst(input logic [2:0] mode, input int cnt, input logic [7:0] d,
                           input logic sir, input logic sil, output int busy_n,
                           output int done_at, output int done_n, output logic [7:0] q_done);
    busy_n = 0; done_at = -1; done_n = 0; q_done = 8'h00;
    i_oe = 1'b1; i_s = mode; i_cnt = CW'(cnt); i_d = d; i_sir = sir; i_sil = sil;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (o_busy) busy_n++;
      if (o_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          q_done  = o_q;
        end
      end
      if (done_at < 0) begin
        i_s   = 3'($urandom);
        i_cnt = CW'($urandom);
      end else begin
        i_s = 3'b000;
      end
      tick();
    end
    i_s = 3'b000;
    $display("burst mode=%0d cnt=%0d busy=%0d done_at=%0d q=%h", mode, cnt, busy_n, done_at, q_done);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    vectors++;
    if (o_q !== 8'h00) begin
      miscompares++; $display("FAIL reset_q: got %h want 00", o_q);
    end
    vectors++;
    if ({o_busy, o_done, o_sor, o_sol} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {o_busy, o_done, o_sor, o_sol});
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    load(8'hA5);
    i_s = 3'b001; i_cnt = CW'(6); i_start = 1'b1;
    tick();
    i_start = 1'b0; i_s = 3'b000;
    tick();
    tick();
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++; $display("FAIL midrst_busy_before: got %b want 1", o_busy);
    end
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_q !== 8'h00) begin
      miscompares++; $display("FAIL midrst_q: got %h want 00", o_q);
    end
    vectors++;
    if ({o_busy, o_done, o_sor, o_sol} !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_flags: got %b want 0000", {o_busy, o_done, o_sor, o_sol});
    end
    tick();
    i_rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_done || o_busy) done_seen++;
      tick();
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++; $display("FAIL midrst_no_done: got %0d busy/done cycles want 0", done_seen);
    end
  endtask

  task automatic test_step_legacy();
    i_oe = 1'b1;
    i_s = 3'b011; i_d = 8'h5A; tick();
    vectors++;
    if (o_q !== 8'h5A) begin miscompares++; $display("FAIL step_load: got %h want 5a", o_q); end
    i_s = 3'b001; i_sir = 1'b1; tick();
    vectors++;
    if (o_q !== 8'hAD) begin miscompares++; $display("FAIL step_shr: got %h want ad", o_q); end
    i_s = 3'b010; i_sil = 1'b0; tick();
    vectors++;
    if (o_q !== 8'h5A) begin miscompares++; $display("FAIL step_shl: got %h want 5a", o_q); end
    i_s = 3'b000; tick(); tick();
    vectors++;
    if (o_q !== 8'h5A) begin miscompares++; $display("FAIL step_hold: got %h want 5a", o_q); end
    i_oe = 1'b0; #1;
    vectors++;
    if ({o_q, o_sol, o_sor} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL oe_off: got q=%h sol=%b sor=%b want 00 0 0", o_q, o_sol, o_sor);
    end
    i_oe = 1'b1; #1;
    vectors++;
    if (o_q !== 8'h5A) begin miscompares++; $display("FAIL oe_restore: got %h want 5a", o_q); end
  endtask

  task automatic test_rotate_asr();
    load(8'h81); i_s = 3'b100; tick();
    vectors++;
    if (o_q !== 8'hC0) begin miscompares++; $display("FAIL ror: got %h want c0", o_q); end
    load(8'h81); i_s = 3'b101; tick();
    vectors++;
    if (o_q !== 8'h03) begin miscompares++; $display("FAIL rol: got %h want 03", o_q); end
    load(8'h80); i_s = 3'b110; i_sir = 1'b0; tick();
    vectors++;
    if (o_q !== 8'hC0) begin miscompares++; $display("FAIL asr1: got %h want c0", o_q); end
    tick();
    vectors++;
    if (o_q !== 8'hE0) begin miscompares++; $display("FAIL asr2: got %h want e0", o_q); end
    i_s = 3'b000;
  endtask

  task automatic test_burst();
    int b, da, dn;
    logic [7:0] qd;
    load(8'h01);
    run_burst(3'b010, 3, 8'h00, 1'b0, 1'b0, b, da, dn, qd);
    vectors++;
    if (b !== 3) begin miscompares++; $display("FAIL burst_busy: got %0d want 3", b); end
    vectors++;
    if (da !== 4 || dn !== 1) begin
      miscompares++; $display("FAIL burst_done: got at=%0d n=%0d want at=4 n=1", da, dn);
    end
    vectors++;
    if (qd !== 8'h08) begin miscompares++; $display("FAIL burst_q: got %h want 08", qd); end
  endtask

  task automatic test_count_bounds();
    int b, da, dn;
    logic [7:0] qd;
    load(8'h77);
    run_burst(3'b001, 0, 8'h00, 1'b1, 1'b0, b, da, dn, qd);
    vectors++;
    if ({b, da, dn} !== {32'd0, 32'd1, 32'd1} || qd !== 8'h77) begin
      miscompares++; $display("FAIL cnt0: got busy=%0d at=%0d n=%0d q=%h want 0 1 1 77", b, da, dn, qd);
    end
    load(8'h3C);
    run_burst(3'b100, 15, 8'h00, 1'b0, 1'b0, b, da, dn, qd);
    vectors++;
    if ({b, da, dn} !== {32'd8, 32'd9, 32'd1} || qd !== 8'h3C) begin
      miscompares++; $display("FAIL cnt15_clamp: got busy=%0d at=%0d n=%0d q=%h want 8 9 1 3c", b, da, dn, qd);
    end
    load(8'h00);
    run_burst(3'b011, 5, 8'hF0, 1'b0, 1'b0, b, da, dn, qd);
    vectors++;
    if ({b, da, dn} !== {32'd1, 32'd2, 32'd1} || qd !== 8'hF0) begin
      miscompares++; $display("FAIL load_once: got busy=%0d at=%0d n=%0d q=%h want 1 2 1 f0", b, da, dn, qd);
    end
  endtask

  task automatic test_back_to_back();
    logic       busy_h [1:8];
    logic       done_h [1:8];
    logic [7:0] q_h    [1:8];
    logic [7:0] v, e1, e2;
    v = 8'($urandom);
    load(v);
    e1 = m_step(m_step(v, 3'd2, 8'h00, 1'b0, 1'b1), 3'd2, 8'h00, 1'b0, 1'b1);
    e2 = m_step(m_step(e1, 3'd2, 8'h00, 1'b0, 1'b1), 3'd2, 8'h00, 1'b0, 1'b1);
    i_oe = 1'b1; i_sil = 1'b1; i_s = 3'b010; i_cnt = CW'(2); i_start = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      busy_h[k] = o_busy; done_h[k] = o_done; q_h[k] = o_q;
      if (k == 5) i_start = 1'b0;
      if (k == 7) i_s = 3'b000;
      tick();
    end
    vectors++;
    if ({busy_h[1], busy_h[2], busy_h[3], done_h[3]} !== 4'b1101) begin
      miscompares++; $display("FAIL b2b_first: got %b want 1101",
                              {busy_h[1], busy_h[2], busy_h[3], done_h[3]});
    end
    vectors++;
    if ({busy_h[4], done_h[4], busy_h[5], busy_h[6]} !== 4'b0011) begin
      miscompares++; $display("FAIL b2b_gap: got %b want 0011",
                              {busy_h[4], done_h[4], busy_h[5], busy_h[6]});
    end
    vectors++;
    if (q_h[3] !== e1 || q_h[4] !== e1) begin
      miscompares++; $display("FAIL b2b_q1: got %h/%h want %h", q_h[3], q_h[4], e1);
    end
    vectors++;
    if (done_h[7] !== 1'b1 || q_h[7] !== e2) begin
      miscompares++; $display("FAIL b2b_q2: got done=%b q=%h want 1 %h", done_h[7], q_h[7], e2);
    end
  endtask

  task automatic test_random_steps();
    logic [7:0] model;
    model = 8'($urandom);
    load(model);
    for (int n = 0; n < 200; n++) begin
      i_s = 3'($urandom); i_d = 8'($urandom);
      i_sir = 1'($urandom); i_sil = 1'($urandom); i_oe = 1'($urandom);
      model = m_step(model, i_s, i_d, i_sir, i_sil);
      tick();
      vectors++;
      if (o_q !== (i_oe ? model : 8'h00) || o_sor !== model[0] || o_sol !== model[7]) begin
        miscompares++;
        $display("FAIL rand_step: s=%0d got q=%h sor=%b sol=%b want q=%h sor=%b sol=%b",
                 i_s, o_q, o_sor, o_sol, (i_oe ? model : 8'h00), model[0], model[7]);
      end
    end
    i_s = 3'b000; i_oe = 1'b1;
  endtask

  task automatic test_random_bursts();
    int b, da, dn, cnt, n;
    logic [7:0] v, d, qd, exp_q;
    logic [2:0] mode;
    logic sir, sil;
    for (int t = 0; t < 20; t++) begin
      v = 8'($urandom); d = 8'($urandom);
      mode = 3'($urandom_range(0, 7));
      cnt = (mode == 3'd3) ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 15));
      n = (mode == 3'd3) ? 1 : ((cnt > W) ? W : cnt);
      sir = 1'($urandom); sil = 1'($urandom);
      exp_q = v;
      for (int k = 0; k < n; k++) exp_q = m_step(exp_q, mode, d, sir, sil);
      load(v);
      run_burst(mode, cnt, d, sir, sil, b, da, dn, qd);
      vectors++;
      if (b !== n || da !== n + 1 || dn !== 1 || qd !== exp_q) begin
        miscompares++;
        $display("FAIL rand_burst: mode=%0d cnt=%0d got busy=%0d at=%0d n=%0d q=%h want %0d %0d 1 %h",
                 mode, cnt, b, da, dn, qd, n, n + 1, exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_step_legacy();
    test_rotate_asr();
    test_burst();
    test_count_bounds();
    test_back_to_back();
    test_random_steps();
    test_random_bursts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the 4-bit, 4-mode shift register.
- Generalised to WIDTH bits, with rotate and arithmetic modes plus serial in/out cascade pins.
- Adds a burst engine: one START request applies an operation CNT times, with a BUSY/DONE handshake.
- Used as a datapath shifter/serializer beside register-file and counter blocks.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- CW, $clog2(WIDTH+1), width of the CNT port (localparam-style; do not override).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- D  in  WIDTH  parallel load data.
- S  in  3  mode select (encoding below).
- SIR  in  1  serial input for shift right; enters the MSB.
- SIL  in  1  serial input for shift left; enters the LSB.
- START  in  1  burst request; sampled only in IDLE.
- CNT  in  CW  burst step count.
- OE  in  1  output enable.
- Q  out  WIDTH  register value when OE=1, all-zero when OE=0 (no tri-state).
- SOR  out  1  internal reg[0], unaffected by OE.
- SOL  out  1  internal reg[WIDTH-1], unaffected by OE.
- BUSY  out  1  high while a burst is in progress.
- DONE  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - reg=0, FSM=IDLE, remaining=0, latched mode=000.
  - Q=0, SOR=0, SOL=0, BUSY=0, DONE=0.
  - Applies mid-burst too: the burst is abandoned and no DONE is emitted.
- Mode encoding S (1 step = 1 edge):
  - 000: hold.
  - 001: shift right, reg <= {SIR, reg[WIDTH-1:1]}.
  - 010: shift left, reg <= {reg[WIDTH-2:0], SIL}.
  - 011: parallel load, reg <= D.
  - 100: rotate right.
  - 101: rotate left.
  - 110: arithmetic shift right; MSB replicated, SIR ignored.
  - 111: reserved, behaves as hold.
- Codes 00/01/10/11 on S[1:0] with S[2]=0 match the legacy 4-mode block.
- OE is purely combinational on Q. It never affects internal state, SOR or SOL.
- FSM states: IDLE, RUN, FIN.
- IDLE, START=0:
  - Step mode: S is applied on every edge (legacy single-step behaviour).
  - BUSY=0.
- IDLE, START=1:
  - On that edge no operation is applied.
  - Latch mode=S and remaining=min(CNT, WIDTH).
  - If the latched mode is 011: remaining forced to 1 (load happens exactly once).
  - If the clamped count is 0: go to FIN. Otherwise go to RUN.
- RUN:
  - BUSY=1. Each edge applies the latched mode once and decrements remaining.
  - SIR/SIL/D are sampled live on each step.
  - S, START and CNT are ignored.
  - On the edge that applies the last step, go to FIN.
- FIN:
  - DONE=1 and BUSY=0 for exactly one cycle; reg holds; then go to IDLE.
  - START is ignored in FIN. A request must wait until IDLE, so back-to-back bursts are separated by one FIN cycle.
- Latency for a burst issued at edge t with N steps (1..WIDTH):
  - BUSY high in cycles t+1 .. t+N.
  - Last step at edge t+N.
  - DONE high in cycle t+N+1.
  - For N=0: DONE in cycle t+1, BUSY never asserted.
- Shift right or left by the full WIDTH fully replaces reg with serial-input bits. No wrap error.
- All shifts are logical except mode 110. Rotation by WIDTH returns the original value.

Decomposition:
- Shared package usr_pkg holds:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR;
  - FSM state typedef (IDLE/RUN/FIN).
- One natural sub-module: usr_step_unit.
  - Purely combinational next-value function of (reg, mode, D, SIR, SIL), WIDTH-parametrised.
  - Shared by step mode and burst mode.
- The top holds the register, FSM, counter and OE gating.

Test Plan (WIDTH=8):
- Reset mid-burst:
  - Stimulus: load 0xA5; START with S=001, CNT=6; drop RST_N in the 3rd RUN cycle.
  - Required: Q=0, BUSY=0 immediately (asynchronously); no DONE pulse afterwards.
- Step mode, legacy codes, OE=1:
  - S=011, D=0x5A: Q=0x5A.
  - S=001, SIR=1: Q=0xAD.
  - S=010, SIL=0: Q=0x5A.
  - S=000: Q stays 0x5A.
  - OE=0: Q=0x00 while internal value is unchanged; SOL=0, SOR=0.
- Rotate and arithmetic, starting from 0x81:
  - S=100: 0xC0.
  - S=101 from 0x81: 0x03.
  - S=110 from 0x80: 0xC0, then 0xE0.
- Burst:
  - Stimulus: 0x01 loaded; START with S=010, SIL=0, CNT=3.
  - Required: BUSY high exactly 3 cycles; Q=0x08; DONE single pulse in the next cycle; S toggled during RUN has no effect.
- Count boundaries:
  - CNT=0: DONE on the next cycle, BUSY never high, Q unchanged.
  - CNT=15 with S=100 on 0x3C: clamped to 8 steps; Q=0x3C at DONE.
  - START with S=011, D=0xF0, CNT=5: exactly 1 BUSY cycle, Q=0xF0.
- START handling around FIN:
  - START held high through FIN is ignored; a new burst begins only on the IDLE edge after FIN.
  - Verify a 1-cycle gap between DONE and the next BUSY.
